// File: rtl/fifomult_param_if.sv
// Operand/product bus for fifomult_param: operand push side plus product and status outputs.
interface fifomult_param_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0]   data_in;
    logic                data_in_parity;
    logic                data_in_valid;
    logic                busy_out;
    logic [2*DATA_W-1:0] data_out;
    logic                data_out_parity;
    logic                data_out_valid;
    logic                data_in_parity_error;
    logic                overflow;
    logic [CNT_W-1:0]    fifo_count;

    modport master (
        output data_in, data_in_parity, data_in_valid,
        input  busy_out, data_out, data_out_parity, data_out_valid,
        input  data_in_parity_error, overflow, fifo_count
    );

    modport slave (
        input  data_in, data_in_parity, data_in_valid,
        output busy_out, data_out, data_out_parity, data_out_valid,
        output data_in_parity_error, overflow, fifo_count
    );
endinterface

// File: rtl/fifomult_param.sv
// Parity-checked operand FIFO feeding an iterative signed shift-add multiplier;
// operands are consumed in pairs and each product is emitted with generated parity.
module fifomult_param #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH      = 8,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    fifomult_param_if.slave bus
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned ITER_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [DEPTH-1:0]  r_mem_err;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_busy;
    logic              r_overflow;

    logic [PROD_W-1:0] r_mcand;
    logic [PROD_W-1:0] r_acc;
    logic [DATA_W-1:0] r_mplier;
    logic [ITER_W-1:0] r_iter;
    logic              r_pair_err;

    logic [PROD_W-1:0] r_data_out;
    logic              r_data_out_parity;
    logic              r_data_out_valid;
    logic              r_parity_error;

    logic              w_push;
    logic              w_pop;
    logic              w_step;
    logic              w_finish;
    logic              w_in_err;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [PTR_W-1:0]  w_rd_ptr_b;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;

    // busy is the registered full flag, so a same-edge pop never frees room for a word offered while full
    assign w_push      = bus.data_in_valid && !r_busy;
    assign w_in_err    = ((^bus.data_in) ^ PARITY_ODD) != bus.data_in_parity;
    assign w_rd_ptr_b  = r_rd_ptr + PTR_W'(1);
    assign w_op_a      = r_mem_data[r_rd_ptr];
    assign w_op_b      = r_mem_data[w_rd_ptr_b];
    assign w_count_nxt = r_count + CNT_W'(w_push) - (w_pop ? CNT_W'(2) : CNT_W'(0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // DONE may pop directly so back-to-back products are DATA_W+2 cycles apart
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (r_count >= CNT_W'(2)) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_MUL;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (r_iter == ITER_W'(DATA_W)) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_step = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem_data[r_wr_ptr] <= bus.data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_err  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem_err[r_wr_ptr] <= w_in_err;
                r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(2);
            if (bus.data_in_valid && r_busy) r_overflow <= 1'b1;
            r_count <= w_count_nxt;
            r_busy  <= (w_count_nxt == CNT_W'(DEPTH));
        end
    end

    // Shift-add over B's bits; B's sign bit carries negative weight, so its partial product is subtracted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand    <= '0;
            r_acc      <= '0;
            r_mplier   <= '0;
            r_iter     <= '0;
            r_pair_err <= 1'b0;
        end else if (w_pop) begin
            r_mcand    <= {{DATA_W{w_op_a[DATA_W-1]}}, w_op_a};
            r_mplier   <= w_op_b;
            r_acc      <= '0;
            r_iter     <= '0;
            r_pair_err <= r_mem_err[r_rd_ptr] | r_mem_err[w_rd_ptr_b];
        end else if (w_step) begin
            if (r_mplier[0]) begin
                r_acc <= (r_iter == ITER_W'(DATA_W - 1)) ? (r_acc - r_mcand) : (r_acc + r_mcand);
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_iter   <= r_iter + ITER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out        <= '0;
            r_data_out_parity <= 1'b0;
            r_data_out_valid  <= 1'b0;
            r_parity_error    <= 1'b0;
        end else begin
            r_data_out_valid <= w_finish;
            if (w_finish) begin
                r_data_out        <= r_pair_err ? '0 : r_acc;
                r_data_out_parity <= r_pair_err ? PARITY_ODD : ((^r_acc) ^ PARITY_ODD);
                r_parity_error    <= r_pair_err;
            end
        end
    end

    assign bus.busy_out             = r_busy;
    assign bus.fifo_count           = r_count;
    assign bus.overflow             = r_overflow;
    assign bus.data_out             = r_data_out;
    assign bus.data_out_parity      = r_data_out_parity;
    assign bus.data_out_valid       = r_data_out_valid;
    assign bus.data_in_parity_error = r_parity_error;
endmodule
